// File: rtl/mw_lsu.sv
// mw_lsu: RV32I load/store unit for the MW stage, req/gnt/rvalid data-memory handshake.
// Optional MW_LSU_MISALIGN_TRAP_EN: flag misaligned accesses instead of force-aligning them.
`default_nettype none

module mw_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        bus_err_o,
    output logic        misalign_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       funct3_q;
    logic [1:0]       lane_q;
    logic             we_q;
    logic [3:0]       be_q;
    logic [29:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             req_q;
    logic             load_valid_q;
    logic             bus_err_q;
    logic [31:0]      load_data_q;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             is_load;
    logic             is_store;
    logic             mem_op;
    logic [1:0]       lane;
    logic [3:0]       be;
    logic [31:0]      wdata_fmt;
    logic [31:0]      shifted;
    logic [31:0]      rdata_fmt;
    logic [CNT_W-1:0] cnt_next;
    logic             timeout;
    logic             unused_bits;

    assign unused_bits = ^{ir_i[31:15], ir_i[11:7]};

    always_comb begin
        opcode   = ir_i[6:0];
        funct3   = ir_i[14:12];
        is_load  = valid_i && (opcode == OP_LOAD) &&
                   (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_store = valid_i && (opcode == OP_STORE) &&
                   (funct3 inside {3'b000, 3'b001, 3'b010});

        // Lane offset with the low bits that cannot matter for the width cleared.
        case (funct3[1:0])
            2'b00:   lane = addr_i[1:0];
            2'b01:   lane = {addr_i[1], 1'b0};
            default: lane = 2'b00;
        endcase

        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << lane;
                wdata_fmt = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << lane;
                wdata_fmt = {2{wdata_i[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_fmt = wdata_i;
            end
        endcase
    end

`ifdef MW_LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((funct3[1:0] == 2'b01) && addr_i[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    assign mem_op     = (is_load || is_store) && !misaligned;
    assign misalign_o = (is_load || is_store) && misaligned;
`else
    assign mem_op     = is_load || is_store;
    assign misalign_o = 1'b0;
`endif

    always_comb begin
        shifted = dmem_rdata_i >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  rdata_fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  rdata_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  rdata_fmt = {24'h0, shifted[7:0]};
            3'b101:  rdata_fmt = {16'h0, shifted[15:0]};
            default: rdata_fmt = dmem_rdata_i;
        endcase
    end

    assign cnt_next = cnt + 1'b1;
    assign timeout  = (cnt_next == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            funct3_q     <= 3'b000;
            lane_q       <= 2'b00;
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_q        <= 1'b0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            load_data_q  <= '0;
        end else begin
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        state    <= REQ;
                        req_q    <= 1'b1;
                        cnt      <= '0;
                        addr_q   <= addr_i[31:2];
                        be_q     <= be;
                        we_q     <= is_store;
                        wdata_q  <= wdata_fmt;
                        funct3_q <= funct3;
                        lane_q   <= lane;
                    end
                end
                REQ: begin
                    cnt <= cnt_next;
                    // Timeout wins over a last-cycle grant so the counter can never run past its limit.
                    if (timeout) begin
                        state       <= DONE;
                        req_q       <= 1'b0;
                        bus_err_q   <= 1'b1;
                        load_data_q <= '0;
                    end else if (dmem_gnt_i) begin
                        state <= WAIT;
                        req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt_next;
                    if (dmem_rvalid_i) begin
                        state <= DONE;
                        if (!we_q) begin
                            load_valid_q <= 1'b1;
                            load_data_q  <= rdata_fmt;
                        end
                    end else if (timeout) begin
                        state       <= DONE;
                        bus_err_q   <= 1'b1;
                        load_data_q <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign stall_o      = ((state == IDLE) && mem_op) || (state == REQ) || (state == WAIT);
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_be_o    = be_q;
    assign dmem_addr_o  = {addr_q, 2'b00};
    assign dmem_wdata_o = wdata_q;
    assign load_data_o  = load_data_q;
    assign load_valid_o = load_valid_q;
    assign bus_err_o    = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mw_lsu.sv
// tb_mw_lsu: directed bench for mw_lsu with a cycle-timeline model and a per-cycle compare process.
`default_nettype none

module tb_mw_lsu;

    localparam int TMO = 16;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [31:0] ir_i, addr_i, wdata_i, dmem_rdata_i;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic        dmem_req_o, dmem_we_o, stall_o, load_valid_o, bus_err_o, misalign_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, load_data_o;

    mw_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ir_i         (ir_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .bus_err_o    (bus_err_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    logic        chk_en = 1'b0;
    logic        exp_req, exp_stall, exp_lv, exp_err, exp_mis, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wd, exp_ld;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: spec-level formulas for instruction encoding, lanes, enables and load formatting.
    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {17'h0, f3, 5'd5, op};
    endfunction

    function automatic logic [1:0] lane_of(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b00) return a[1:0];
        if (f3[1:0] == 2'b01) return {a[1], 1'b0};
        return 2'b00;
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m << lane_of(f3, a);
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * int'(lane_of(f3, a)));
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b100:  return {24'h0, v[7:0]};
            3'b101:  return {16'h0, v[15:0]};
            default: return rd;
        endcase
    endfunction

    function automatic logic mis_of(input logic v, input logic [31:0] ir, input logic [31:0] a);
`ifdef MW_LSU_MISALIGN_TRAP_EN
        logic [2:0] f3;
        logic       mem;
        f3  = ir[14:12];
        mem = ((ir[6:0] == LOAD)  && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
              ((ir[6:0] == STORE) && (f3 inside {3'b000, 3'b001, 3'b010}));
        return v && mem && (((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)));
`else
        return 1'b0 & v & ir[0] & a[0];
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req",        32'(dmem_req_o),   32'(exp_req));
            chk("stall",      32'(stall_o),      32'(exp_stall));
            chk("load_valid", 32'(load_valid_o), 32'(exp_lv));
            chk("bus_err",    32'(bus_err_o),    32'(exp_err));
            chk("misalign",   32'(misalign_o),   32'(exp_mis));
            chk("load_data",  load_data_o,       exp_ld);
            if (exp_req) begin
                chk("addr", dmem_addr_o,       exp_addr);
                chk("be",   32'(dmem_be_o),    32'(exp_be));
                chk("we",   32'(dmem_we_o),    32'(exp_we));
                if (exp_we) chk("wdata", dmem_wdata_o, exp_wd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // g: REQ cycle index of gnt; r: WAIT cycle index of rvalid (negative = never).
    task automatic run_op(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int g, input int r,
                          input logic [31:0] h_addr, input logic [3:0] h_be, input logic [31:0] h_val);
        logic [2:0] f3;
        logic       ld, in_req, ok, tmo;
        int         wc;
        f3 = ir[14:12];
        ld = (ir[6:0] == LOAD);
        valid_i = 1'b1; ir_i = ir; addr_i = a; wdata_i = wd;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b1; exp_lv = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
        exp_addr = {a[31:2], 2'b00}; exp_be = be_of(f3, a); exp_we = !ld; exp_wd = wdata_of(f3, wd);
        step();
        in_req = 1'b1; ok = 1'b0; tmo = 1'b1; wc = 0;
        for (int c = 0; c < TMO; c++) begin
            exp_stall = 1'b1; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
            if (in_req) begin
                exp_req = 1'b1;
                dmem_gnt_i = (c == g);
                if (c == 0) begin
                    #2;
                    chk("hand_addr", dmem_addr_o, h_addr);
                    chk("hand_be", 32'(dmem_be_o), 32'(h_be));
                    if (!ld) chk("hand_wdata", dmem_wdata_o, h_val);
                end
                if (c == g) in_req = 1'b0;
            end else begin
                exp_req = 1'b0;
                if (wc == r) begin
                    dmem_rvalid_i = 1'b1; dmem_rdata_i = rd; ok = 1'b1;
                end
                wc++;
            end
            step();
            if (ok) begin
                tmo = 1'b0;
                break;
            end
        end
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0;
        exp_lv = ld && !tmo; exp_err = tmo;
        if (tmo) exp_ld = 32'h0;
        else if (ld) exp_ld = load_of(f3, a, rd);
        #2;
        if (ld && !tmo) chk("hand_load", load_data_o, h_val);
        step();
        valid_i = 1'b0; exp_lv = 1'b0; exp_err = 1'b0;
    endtask

    task automatic idle_op(input logic v, input logic [31:0] ir, input logic [31:0] a, input int n);
        valid_i = v; ir_i = ir; addr_i = a;
        exp_req = 1'b0; exp_stall = 1'b0; exp_lv = 1'b0; exp_err = 1'b0;
        exp_mis = mis_of(v, ir, a);
        repeat (n) step();
        valid_i = 1'b0; exp_mis = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; ir_i = '0; addr_i = '0; wdata_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_lv = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
        exp_we = 1'b0; exp_be = '0; exp_addr = '0; exp_wd = '0; exp_ld = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_req",   32'(dmem_req_o),   32'h0);
        chk("rst_stall", 32'(stall_o),      32'h0);
        chk("rst_lv",    32'(load_valid_o), 32'h0);
        chk("rst_data",  load_data_o,       32'h0);
        chk_en = 1'b1;
        step(); step();
        rst = 1'b1;
        step();

        run_op(mk(3'b010, LOAD),  32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 32'h100, 4'b1111, 32'hDEADBEEF);
        run_op(mk(3'b000, LOAD),  32'h103, 32'h0,        32'h80FFFFFF, 0, 0, 32'h100, 4'b1000, 32'hFFFFFF80);
        run_op(mk(3'b100, LOAD),  32'h103, 32'h0,        32'h80FFFFFF, 0, 0, 32'h100, 4'b1000, 32'h00000080);
        run_op(mk(3'b001, STORE), 32'h202, 32'h1234ABCD, 32'h0,        3, 0, 32'h200, 4'b1100, 32'hABCDABCD);
        run_op(mk(3'b001, LOAD),  32'h002, 32'h0,        32'h80017FFF, 1, 2, 32'h000, 4'b1100, 32'hFFFF8001);
        run_op(mk(3'b101, LOAD),  32'h000, 32'h0,        32'h12348001, 0, 0, 32'h000, 4'b0011, 32'h00008001);
        run_op(mk(3'b000, STORE), 32'h301, 32'h000000A5, 32'h0,        0, 0, 32'h300, 4'b0010, 32'hA5A5A5A5);
        run_op(mk(3'b010, STORE), 32'h400, 32'hCAFEF00D, 32'h0,        0, 1, 32'h400, 4'b1111, 32'hCAFEF00D);

        idle_op(1'b1, mk(3'b011, LOAD),  32'h100, 2);
        idle_op(1'b1, mk(3'b100, STORE), 32'h100, 2);
        idle_op(1'b0, mk(3'b010, LOAD),  32'h100, 2);
        idle_op(1'b1, mk(3'b010, 7'b0110011), 32'h100, 2);

        // Reset asserted mid-transaction while waiting for rvalid.
        valid_i = 1'b1; ir_i = mk(3'b010, LOAD); addr_i = 32'h600;
        exp_stall = 1'b1; exp_addr = 32'h600; exp_be = 4'hF; exp_we = 1'b0;
        step();
        exp_req = 1'b1; dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0; exp_req = 1'b0;
        step();
        rst = 1'b0; valid_i = 1'b0; exp_stall = 1'b0; exp_ld = 32'h0;
        #1;
        chk("arst_req",   32'(dmem_req_o),   32'h0);
        chk("arst_stall", 32'(stall_o),      32'h0);
        chk("arst_data",  load_data_o,       32'h0);
        step(); step();
        rst = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
        step();
        dmem_rvalid_i = 1'b0;
        step(); step();

        // Timeout, then a late rvalid and a stray gnt in IDLE.
        run_op(mk(3'b010, LOAD), 32'h500, 32'h0, 32'h0, 0, -1, 32'h500, 4'b1111, 32'h0);
        dmem_rvalid_i = 1'b1; dmem_gnt_i = 1'b1; dmem_rdata_i = 32'h55555555;
        step();
        dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0;
        step();

`ifdef MW_LSU_MISALIGN_TRAP_EN
        idle_op(1'b1, mk(3'b010, LOAD), 32'h101, 1);
        valid_i = 1'b1; addr_i = 32'h101; exp_mis = 1'b1;
        #1;
        chk("hand_misalign", 32'(misalign_o), 32'h1);
        step();
        valid_i = 1'b0; exp_mis = 1'b0;
        step();
`else
        run_op(mk(3'b010, LOAD), 32'h101, 32'h0, 32'h11223344, 0, 0, 32'h100, 4'b1111, 32'h11223344);
`endif
        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
